// File: rtl/pcileech_ft601_responder.sv
// pcileech_ft601_responder - device-side FT601 245 sync FIFO model with host buffer, write capture and TXE throttle.
// Optional protocol checker: define PCILEECH_FT601_RESP_ERRCHK_EN to build err_flags.
module pcileech_ft601_responder #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned TXE_BURST  = 1024,
  parameter int unsigned TXE_GAP    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ft601_data_in,
  output logic [31:0] ft601_data_out,
  output logic        ft601_data_oe,
  input  logic [3:0]  ft601_be,
  output logic        ft601_rxf_n,
  output logic        ft601_txe_n,
  input  logic        ft601_wr_n,
  input  logic        ft601_rd_n,
  input  logic        ft601_oe_n,
  input  logic [31:0] host_tx_data,
  input  logic        host_tx_valid,
  output logic        host_tx_ready,
  output logic [31:0] host_rx_data,
  output logic [3:0]  host_rx_be,
  output logic        host_rx_valid,
  output logic [3:0]  err_flags
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned BW    = (TXE_BURST > 2) ? $clog2(TXE_BURST) : 1;
  localparam int unsigned GW    = $clog2(TXE_GAP + 1);

  localparam logic [DEPTH_LOG2:0]   CNT_FULL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [BW-1:0]         BST_ONE  = BW'(1);
  localparam logic [GW-1:0]         GAP_ONE  = GW'(1);
  localparam logic [GW-1:0]         GAP_LOAD = GW'(TXE_GAP);

  localparam logic [0:0] ST_OPEN = 1'b0;
  localparam logic [0:0] ST_GAP  = 1'b1;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr_next;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_next;
  logic [DEPTH_LOG2:0]   resident;
  logic                  push;
  logic                  pop;
  logic                  wr_accept;

  logic [0:0]    state;
  logic [BW-1:0] burst_cnt;
  logic [GW-1:0] gap_cnt;
  logic          burst_done;

  assign ft601_data_oe = ~ft601_oe_n;
  assign host_tx_ready = (count != CNT_FULL);
  assign push          = host_tx_valid & host_tx_ready;
  assign pop           = ~ft601_rd_n & ~ft601_oe_n & (count != '0);
  assign wr_accept     = ~ft601_wr_n & ~ft601_txe_n;
  assign rd_ptr_next   = pop ? rd_ptr + PTR_ONE : rd_ptr;
  // Words already in RAM before this edge; a word pushed now is not readable until next edge.
  assign resident      = pop ? count - CNT_ONE : count;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= host_tx_data;
    end
  end

  // rxf_n tracks the prefetch register, so it never advertises a word not yet on the pads.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      ft601_rxf_n    <= 1'b1;
      ft601_data_out <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr      <= rd_ptr_next;
      count       <= count_next;
      ft601_rxf_n <= (resident == '0);
      if (resident != '0) begin
        ft601_data_out <= mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      host_rx_valid <= 1'b0;
      host_rx_data  <= '0;
      host_rx_be    <= '0;
    end else begin
      host_rx_valid <= wr_accept;
      if (wr_accept) begin
        host_rx_data <= ft601_data_in;
        host_rx_be   <= ft601_be;
      end
    end
  end

  assign burst_done = (TXE_BURST != 0) && wr_accept && ((32'(burst_cnt) + 32'd1) == TXE_BURST);

  // txe_n is held high through reset and drops on the first edge after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_OPEN;
      burst_cnt   <= '0;
      gap_cnt     <= '0;
      ft601_txe_n <= 1'b1;
    end else begin
      case (state)
        ST_OPEN: begin
          if (burst_done) begin
            state       <= ST_GAP;
            burst_cnt   <= '0;
            gap_cnt     <= GAP_LOAD;
            ft601_txe_n <= 1'b1;
          end else begin
            if (wr_accept) begin
              burst_cnt <= burst_cnt + BST_ONE;
            end
            ft601_txe_n <= 1'b0;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_ONE) begin
            state       <= ST_OPEN;
            ft601_txe_n <= 1'b0;
          end else begin
            gap_cnt     <= gap_cnt - GAP_ONE;
            ft601_txe_n <= 1'b1;
          end
        end
        default: begin
          state       <= ST_OPEN;
          ft601_txe_n <= 1'b1;
        end
      endcase
    end
  end

`ifdef PCILEECH_FT601_RESP_ERRCHK_EN
  logic [3:0] err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | {~ft601_wr_n & ~ft601_oe_n,
                        ~ft601_rd_n & ft601_oe_n,
                        ~ft601_wr_n & ft601_txe_n,
                        ~ft601_rd_n & (count == '0)};
    end
  end

  assign err_flags = err_q;
`else
  assign err_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_pcileech_ft601_responder.sv
// tb/tb_pcileech_ft601_responder.sv - directed table, corner sequences and random traffic against a queue model.
module tb_pcileech_ft601_responder;

  localparam int DEPTH = 512;
  localparam int BURST = 4;
  localparam int GAP   = 4;
`ifdef PCILEECH_FT601_RESP_ERRCHK_EN
  localparam logic [3:0] ERR_MASK = 4'hF;
`else
  localparam logic [3:0] ERR_MASK = 4'h0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ft601_data_in = '0;
  logic [31:0] ft601_data_out;
  logic        ft601_data_oe;
  logic [3:0]  ft601_be = 4'hF;
  logic        ft601_rxf_n;
  logic        ft601_txe_n;
  logic        ft601_wr_n = 1'b1;
  logic        ft601_rd_n = 1'b1;
  logic        ft601_oe_n = 1'b1;
  logic [31:0] host_tx_data = '0;
  logic        host_tx_valid = 1'b0;
  logic        host_tx_ready;
  logic [31:0] host_rx_data;
  logic [3:0]  host_rx_be;
  logic        host_rx_valid;
  logic [3:0]  err_flags;

  always #5 clk = ~clk;

  pcileech_ft601_responder #(.DEPTH_LOG2(9), .TXE_BURST(BURST), .TXE_GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .ft601_data_in(ft601_data_in), .ft601_data_out(ft601_data_out), .ft601_data_oe(ft601_data_oe),
    .ft601_be(ft601_be), .ft601_rxf_n(ft601_rxf_n), .ft601_txe_n(ft601_txe_n),
    .ft601_wr_n(ft601_wr_n), .ft601_rd_n(ft601_rd_n), .ft601_oe_n(ft601_oe_n),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
    .host_rx_data(host_rx_data), .host_rx_be(host_rx_be), .host_rx_valid(host_rx_valid),
    .err_flags(err_flags)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a word is readable once it has sat in the queue across one edge.
  typedef struct {logic [31:0] data; int stamp;} entry_t;
  entry_t      q[$];
  int          edge_no = 0;
  logic [31:0] m_dout, m_rxd;
  logic [3:0]  m_rxbe, m_err;
  logic        m_rxf, m_txe, m_rxv;
  int          gap_left, burst_n;

  task model_step();
    logic push, pop, acc;
    if (rst) begin
      q.delete();
      m_dout = '0; m_rxd = '0; m_rxbe = '0; m_err = '0;
      m_rxf = 1'b1; m_txe = 1'b1; m_rxv = 1'b0;
      gap_left = 0; burst_n = 0;
    end else begin
      push = host_tx_valid && (q.size() != DEPTH);
      pop  = !ft601_rd_n && !ft601_oe_n && (q.size() != 0);
      acc  = !ft601_wr_n && !m_txe;
      m_err |= {(!ft601_wr_n && !ft601_oe_n), (!ft601_rd_n && ft601_oe_n),
                (!ft601_wr_n && m_txe), (!ft601_rd_n && q.size() == 0)};
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{host_tx_data, edge_no});
      if (q.size() != 0 && q[0].stamp < edge_no) begin
        m_dout = q[0].data;
        m_rxf  = 1'b0;
      end else begin
        m_rxf  = 1'b1;
      end
      m_rxv = acc;
      if (acc) begin
        m_rxd  = ft601_data_in;
        m_rxbe = ft601_be;
      end
      if (gap_left > 0) begin
        gap_left--;
      end else if (acc) begin
        burst_n++;
        if (BURST != 0 && burst_n == BURST) begin
          gap_left = GAP;
          burst_n  = 0;
        end
      end
      m_txe = (gap_left > 0);
    end
    edge_no++;
  endtask

  task check_outputs();
    chk("model rxf_n", ft601_rxf_n, m_rxf);
    chk("model txe_n", ft601_txe_n, m_txe);
    chk("model data_out", ft601_data_out, m_dout);
    chk("model tx_ready", host_tx_ready, (q.size() != DEPTH));
    chk("model rx_valid", host_rx_valid, m_rxv);
    chk("model rx_data", host_rx_data, m_rxd);
    chk("model rx_be", host_rx_be, m_rxbe);
    chk("model err_flags", err_flags, m_err & ERR_MASK);
    chk("data_oe", ft601_data_oe, !ft601_oe_n);
  endtask

  task tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  typedef struct {
    logic rst; logic tv; logic [31:0] td; logic rd_n; logic oe_n; logic wr_n; logic [31:0] din;
    logic x_rxf; logic x_txe; logic [31:0] x_dout; logic x_rxv; logic [31:0] x_rxd; logic [3:0] x_err;
  } vec_t;
  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rst  tv   td            rd   oe   wr   din        rxf  txe  dout          rxv  rxd        err
    vecs[0]  = '{1'b1,1'b0,32'h0,        1'b1,1'b1,1'b1,32'h0,     1'b1,1'b1,32'h0,        1'b0,32'h0,    4'h0};
    vecs[1]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,32'h0,     1'b1,1'b0,32'h0,        1'b0,32'h0,    4'h0};
    vecs[2]  = '{1'b0,1'b1,32'h11111111, 1'b1,1'b1,1'b1,32'h0,     1'b1,1'b0,32'h0,        1'b0,32'h0,    4'h0};
    vecs[3]  = '{1'b0,1'b1,32'h22222222, 1'b1,1'b1,1'b1,32'h0,     1'b0,1'b0,32'h11111111, 1'b0,32'h0,    4'h0};
    vecs[4]  = '{1'b0,1'b1,32'h33333333, 1'b1,1'b1,1'b1,32'h0,     1'b0,1'b0,32'h11111111, 1'b0,32'h0,    4'h0};
    vecs[5]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h0,     1'b0,1'b0,32'h22222222, 1'b0,32'h0,    4'h0};
    vecs[6]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h0,     1'b0,1'b0,32'h33333333, 1'b0,32'h0,    4'h0};
    vecs[7]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h0,     1'b1,1'b0,32'h33333333, 1'b0,32'h0,    4'h0};
    vecs[8]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h0,     1'b1,1'b0,32'h33333333, 1'b0,32'h0,    4'h1};
    vecs[9]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,32'hA0,    1'b1,1'b0,32'h33333333, 1'b1,32'hA0,   4'h1};
    vecs[10] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,32'hA1,    1'b1,1'b0,32'h33333333, 1'b1,32'hA1,   4'h1};
    vecs[11] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,32'hA2,    1'b1,1'b0,32'h33333333, 1'b1,32'hA2,   4'h1};
    vecs[12] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,32'hA3,    1'b1,1'b1,32'h33333333, 1'b1,32'hA3,   4'h1};
    vecs[13] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,32'hA4,    1'b1,1'b1,32'h33333333, 1'b0,32'hA3,   4'h3};
    vecs[14] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,32'hA5,    1'b1,1'b1,32'h33333333, 1'b0,32'hA3,   4'h3};
    vecs[15] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,32'h0,     1'b1,1'b1,32'h33333333, 1'b0,32'hA3,   4'h3};
    vecs[16] = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b1,32'h0,     1'b1,1'b0,32'h33333333, 1'b0,32'hA3,   4'h3};
    vecs[17] = '{1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'hB0,    1'b1,1'b0,32'h33333333, 1'b1,32'hB0,   4'hB};
    vecs[18] = '{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h0,     1'b1,1'b0,32'h33333333, 1'b0,32'hB0,   4'hF};

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; host_tx_valid = vecs[i].tv; host_tx_data = vecs[i].td;
      ft601_rd_n = vecs[i].rd_n; ft601_oe_n = vecs[i].oe_n; ft601_wr_n = vecs[i].wr_n;
      ft601_data_in = vecs[i].din; ft601_be = 4'hF;
      tick();
      chk($sformatf("vec%0d rxf_n", i), ft601_rxf_n, vecs[i].x_rxf);
      chk($sformatf("vec%0d txe_n", i), ft601_txe_n, vecs[i].x_txe);
      chk($sformatf("vec%0d data_out", i), ft601_data_out, vecs[i].x_dout);
      chk($sformatf("vec%0d rx_valid", i), host_rx_valid, vecs[i].x_rxv);
      chk($sformatf("vec%0d rx_data", i), host_rx_data, vecs[i].x_rxd);
      chk($sformatf("vec%0d err_flags", i), err_flags, vecs[i].x_err & ERR_MASK);
    end

    // Fill to capacity, then pop+push at full, then drain across the pointer wrap.
    ft601_rd_n = 1'b1; ft601_oe_n = 1'b1; ft601_wr_n = 1'b1; host_tx_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      host_tx_data = 32'h1000 + i;
      tick();
    end
    chk("full ready low", host_tx_ready, 0);
    host_tx_data = 32'hDEAD0001; ft601_rd_n = 1'b0; ft601_oe_n = 1'b0;
    tick();
    chk("pop at full ready", host_tx_ready, 1);
    ft601_rd_n = 1'b1; ft601_oe_n = 1'b1;
    tick();
    chk("push after full pop", host_tx_ready, 0);
    host_tx_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ft601_rd_n = 1'b0; ft601_oe_n = 1'b0;
      chk($sformatf("wrap read %0d", i), ft601_data_out, (i < DEPTH - 1) ? 32'h1001 + i : 32'hDEAD0001);
      tick();
    end
    ft601_rd_n = 1'b1; ft601_oe_n = 1'b1;
    chk("drained rxf_n", ft601_rxf_n, 1);

    // Reset with data buffered and the throttle in its gap.
    host_tx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      host_tx_data = 32'h5000 + i;
      tick();
    end
    host_tx_valid = 1'b0; ft601_wr_n = 1'b0; ft601_data_in = 32'hE0;
    for (int i = 0; i < 8 && !m_txe; i++) tick();
    ft601_wr_n = 1'b1;
    chk("gap before reset", ft601_txe_n, 1);
    rst = 1'b1;
    tick();
    chk("reset rxf_n", ft601_rxf_n, 1);
    chk("reset txe_n", ft601_txe_n, 1);
    chk("reset ready", host_tx_ready, 1);
    chk("reset data_out", ft601_data_out, 0);
    rst = 1'b0;
    tick();
    chk("release txe_n", ft601_txe_n, 0);
    host_tx_valid = 1'b1; host_tx_data = 32'hC0DE0001;
    tick();
    host_tx_valid = 1'b0;
    tick();
    chk("post reset rxf_n", ft601_rxf_n, 0);
    chk("post reset word", ft601_data_out, 32'hC0DE0001);
    ft601_rd_n = 1'b0; ft601_oe_n = 1'b0;
    tick();
    ft601_rd_n = 1'b1; ft601_oe_n = 1'b1;
    chk("post reset empty", ft601_rxf_n, 1);

    // Randomized bus traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst = ($urandom_range(0, 299) == 0);
      host_tx_valid = $urandom_range(0, 1);
      host_tx_data = $urandom;
      r = $urandom_range(0, 9);
      ft601_rd_n = !(r < 5);
      ft601_oe_n = !(r < 4 || r == 5);
      ft601_wr_n = $urandom_range(0, 1);
      ft601_data_in = $urandom;
      ft601_be = 4'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
